// File: rtl/mips_issuer_if.sv
// Bundle between the program loader, the issuer and the executor.
// The master side is the loader/executor; the slave side is mips_issuer.
interface mips_issuer_if;
    localparam int unsigned IW = 32;
    localparam int unsigned DW = 16;
    localparam int unsigned FW = 4;

    logic          load_valid;
    logic [2:0]    load_op;
    logic [2:0]    load_rs;
    logic [2:0]    load_rt;
    logic [2:0]    load_rd;
    logic [DW-1:0] load_imm;
    logic          load_ready;
    logic          start;
    logic          instr_valid;
    logic [IW-1:0] instr;
    logic          resp_valid;
    logic          resp_fail;
    logic [DW-1:0] resp_r0, resp_r1, resp_r2, resp_r3, resp_r4, resp_r5;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [FW-1:0] fail_count;
    logic [DW-1:0] res_0, res_1, res_2, res_3, res_4, res_5;

    modport master (
        output load_valid, load_op, load_rs, load_rt, load_rd, load_imm, start,
        output resp_valid, resp_fail, resp_r0, resp_r1, resp_r2, resp_r3, resp_r4, resp_r5,
        input  load_ready, instr_valid, instr, busy, done, timeout, fail_count,
        input  res_0, res_1, res_2, res_3, res_4, res_5
    );

    modport slave (
        input  load_valid, load_op, load_rs, load_rt, load_rd, load_imm, start,
        input  resp_valid, resp_fail, resp_r0, resp_r1, resp_r2, resp_r3, resp_r4, resp_r5,
        output load_ready, instr_valid, instr, busy, done, timeout, fail_count,
        output res_0, res_1, res_2, res_3, res_4, res_5
    );
endinterface

// File: rtl/mips_issuer.sv
// Buffers up to 8 encoded MIPS instructions, issues them back-to-back on start,
// then collects executor responses with a drain timeout.
module mips_issuer (
    input  logic         clk,
    input  logic         rst,
    mips_issuer_if.slave bus
);
    localparam int unsigned IW    = 32;
    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned PW    = 3;
    localparam int unsigned CW    = 4;
    localparam int unsigned TW    = 3;
    localparam int unsigned NRES  = 6;
    localparam logic [TW-1:0] TMAX = TW'(7);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;
    typedef enum logic [2:0] {OP_ADD, OP_AND, OP_OR, OP_NOR, OP_SLL, OP_SRL, OP_ADDI, OP_ILL} op_t;

    function automatic logic [4:0] map_reg(input logic [2:0] idx);
        case (idx)
            3'd0:    map_reg = 5'd17;
            3'd1:    map_reg = 5'd18;
            3'd2:    map_reg = 5'd8;
            3'd3:    map_reg = 5'd23;
            3'd4:    map_reg = 5'd31;
            3'd5:    map_reg = 5'd16;
            default: map_reg = 5'd0;
        endcase
    endfunction

    function automatic logic [IW-1:0] encode(input logic [2:0] op, input logic [2:0] rs,
                                             input logic [2:0] rt, input logic [2:0] rd,
                                             input logic [DW-1:0] imm);
        logic [4:0] s;
        logic [4:0] t;
        logic [4:0] d;
        s = map_reg(rs);
        t = map_reg(rt);
        d = map_reg(rd);
        case (op_t'(op))
            OP_ADD:  encode = {6'b000000, s, t, d, 5'b00000, 6'b100000};
            OP_AND:  encode = {6'b000000, s, t, d, 5'b00000, 6'b100100};
            OP_OR:   encode = {6'b000000, s, t, d, 5'b00000, 6'b100101};
            OP_NOR:  encode = {6'b000000, s, t, d, 5'b00000, 6'b100111};
            OP_SLL:  encode = {6'b000000, 5'b00000, t, d, imm[4:0], 6'b000000};
            OP_SRL:  encode = {6'b000000, 5'b00000, t, d, imm[4:0], 6'b000010};
            OP_ADDI: encode = {6'b001000, s, t, imm};
            default: encode = {6'b111111, 26'b0};
        endcase
    endfunction

    state_t        r_state;
    state_t        w_state_nxt;
    logic [IW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;
    logic          r_load_ready;
    logic          r_instr_valid;
    logic [IW-1:0] r_instr;
    logic [CW-1:0] r_issue_cnt;
    logic [CW-1:0] r_resp_cnt;
    logic [CW-1:0] w_resp_cnt_nxt;
    logic [CW-1:0] r_fail_cnt;
    logic [TW-1:0] r_timer;
    logic          r_timeout;
    logic          r_done;
    logic          r_busy;
    logic [DW-1:0] r_res [NRES];
    logic [DW-1:0] w_resp_vals [NRES];
    logic          w_push;
    logic          w_pop;
    logic          w_start_acc;
    logic          w_resp;
    logic          w_timeout_exit;

    assign w_resp_vals[0] = bus.resp_r0;
    assign w_resp_vals[1] = bus.resp_r1;
    assign w_resp_vals[2] = bus.resp_r2;
    assign w_resp_vals[3] = bus.resp_r3;
    assign w_resp_vals[4] = bus.resp_r4;
    assign w_resp_vals[5] = bus.resp_r5;

    // load_ready is only ever high in IDLE, so a push implies IDLE
    assign w_push         = bus.load_valid && r_load_ready;
    assign w_pop          = (r_state == S_ISSUE);
    assign w_start_acc    = (r_state == S_IDLE) && bus.start && (r_count != '0);
    assign w_resp         = bus.resp_valid && ((r_state == S_ISSUE) || (r_state == S_DRAIN));
    assign w_resp_cnt_nxt = w_resp ? (r_resp_cnt + CW'(1)) : r_resp_cnt;
    assign w_count_nxt    = r_count + CW'(w_push) - CW'(w_pop);

    always_comb begin
        w_state_nxt    = r_state;
        w_timeout_exit = 1'b0;
        case (r_state)
            S_IDLE:  if (w_start_acc) w_state_nxt = S_ISSUE;
            S_ISSUE: if (r_count == CW'(1)) w_state_nxt = S_DRAIN;
            S_DRAIN: begin
                if (w_resp_cnt_nxt == r_issue_cnt) begin
                    w_state_nxt = S_DONE;
                end else if (!w_resp && (r_timer == TMAX)) begin
                    w_state_nxt    = S_DONE;
                    w_timeout_exit = 1'b1;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Storage is not reset; emptiness is tracked by r_count alone
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= encode(bus.load_op, bus.load_rs, bus.load_rt, bus.load_rd, bus.load_imm);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_load_ready  <= 1'b1;
            r_instr_valid <= 1'b0;
            r_instr       <= '0;
            r_issue_cnt   <= '0;
            r_resp_cnt    <= '0;
            r_fail_cnt    <= '0;
            r_timer       <= '0;
            r_timeout     <= 1'b0;
            r_done        <= 1'b0;
            r_busy        <= 1'b0;
            for (int i = 0; i < int'(NRES); i++) r_res[i] <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_count       <= w_count_nxt;
            r_load_ready  <= (w_state_nxt == S_IDLE) && (w_count_nxt != CW'(DEPTH));
            r_done        <= (w_state_nxt == S_DONE);
            r_busy        <= (w_state_nxt != S_IDLE);
            r_instr_valid <= w_pop;
            r_instr       <= w_pop ? r_mem[r_rd_ptr] : '0;
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);

            // Timer only runs in DRAIN while no response arrives
            if ((r_state == S_DRAIN) && !w_resp && (r_timer != TMAX)) r_timer <= r_timer + TW'(1);
            else                                                     r_timer <= '0;

            if (w_start_acc) begin
                r_issue_cnt <= '0;
                r_resp_cnt  <= '0;
                r_fail_cnt  <= '0;
                r_timeout   <= 1'b0;
                for (int i = 0; i < int'(NRES); i++) r_res[i] <= '0;
            end else begin
                if (w_pop) r_issue_cnt <= r_issue_cnt + CW'(1);
                if (w_resp) begin
                    r_resp_cnt <= w_resp_cnt_nxt;
                    if (bus.resp_fail) r_fail_cnt <= r_fail_cnt + CW'(1);
                    for (int i = 0; i < int'(NRES); i++) r_res[i] <= w_resp_vals[i];
                end
                if (w_timeout_exit) r_timeout <= 1'b1;
            end
        end
    end

    assign bus.load_ready  = r_load_ready;
    assign bus.instr_valid = r_instr_valid;
    assign bus.instr       = r_instr;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.timeout     = r_timeout;
    assign bus.fail_count  = r_fail_cnt;
    assign bus.res_0       = r_res[0];
    assign bus.res_1       = r_res[1];
    assign bus.res_2       = r_res[2];
    assign bus.res_3       = r_res[3];
    assign bus.res_4       = r_res[4];
    assign bus.res_5       = r_res[5];
endmodule

// File: tb/tb_mips_issuer.sv
// Scoreboard bench for mips_issuer: expected encodings are queued at load time
// and popped as instructions appear on the issue port.
module tb_mips_issuer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    logic [31:0] q_exp [$];
    logic [31:0] log_q [$];
    logic [31:0] exp_i;
    logic [15:0] exp_res [6];
    logic [31:0] rmap   [8] = '{32'd17, 32'd18, 32'd8, 32'd23, 32'd31, 32'd16, 32'd0, 32'd0};
    logic [31:0] functs [8] = '{32'd32, 32'd36, 32'd37, 32'd39, 32'd0, 32'd2, 32'd0, 32'd0};

    mips_issuer_if bus();

    mips_issuer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] tb_enc(input logic [2:0] op, input logic [2:0] rs,
                                           input logic [2:0] rt, input logic [2:0] rd,
                                           input logic [15:0] imm);
        logic [31:0] s, t, d, sh;
        s  = rmap[rs];
        t  = rmap[rt];
        d  = rmap[rd];
        sh = 32'(imm[4:0]);
        case (op)
            3'd0, 3'd1, 3'd2, 3'd3: return (s << 21) | (t << 16) | (d << 11) | functs[op];
            3'd4, 3'd5:             return (t << 16) | (d << 11) | (sh << 6) | functs[op];
            3'd6:                   return (32'd8 << 26) | (s << 21) | (t << 16) | 32'(imm);
            default:                return 32'd63 << 26;
        endcase
    endfunction

    // Issue-port monitor: every valid instruction must match the next queued encoding
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.instr_valid) begin
                chk("issue_expected", 32'(q_exp.size() != 0), 32'd1);
                if (q_exp.size() != 0) begin
                    exp_i = q_exp.pop_front();
                    chk("instr", bus.instr, exp_i);
                end
                log_q.push_back(bus.instr);
            end else begin
                chk("instr_idle_zero", bus.instr, 32'd0);
            end
        end
    end

    task automatic do_load(input logic [2:0] op, input logic [2:0] rs, input logic [2:0] rt,
                           input logic [2:0] rd, input logic [15:0] imm);
        chk("load_ready", 32'(bus.load_ready), 32'(q_exp.size() < 8));
        bus.load_valid = 1'b1;
        bus.load_op    = op;
        bus.load_rs    = rs;
        bus.load_rt    = rt;
        bus.load_rd    = rd;
        bus.load_imm   = imm;
        if (q_exp.size() < 8) q_exp.push_back(tb_enc(op, rs, rt, rd, imm));
        tick();
        bus.load_valid = 1'b0;
    endtask

    task automatic chk_empty_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("empty_start_busy", 32'(bus.busy), 32'd0);
        tick();
        chk("empty_start_issue", 32'(bus.instr_valid), 32'd0);
    endtask

    task automatic run_prog(input int n_resp, input logic [7:0] fmask, output int n_iss, output int lat);
        int guard;
        int exp_fail;
        log_q.delete();
        exp_fail = 0;
        for (int j = 0; j < 6; j++) exp_res[j] = 16'd0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("busy_after_start", 32'(bus.busy), 32'd1);
        chk("timeout_cleared", 32'(bus.timeout), 32'd0);
        chk("fail_cleared", 32'(bus.fail_count), 32'd0);
        chk("no_issue_at_start", 32'(bus.instr_valid), 32'd0);
        chk("ready_low_busy", 32'(bus.load_ready), 32'd0);
        // A load attempted while issuing must be ignored
        bus.load_valid = 1'b1;
        bus.load_op    = 3'd7;
        tick();
        bus.load_valid = 1'b0;
        chk("first_issue", 32'(bus.instr_valid), 32'd1);
        n_iss = 0;
        guard = 0;
        while (bus.instr_valid && guard < 20) begin
            n_iss++;
            guard++;
            tick();
        end
        for (int k = 0; k < n_resp; k++) begin
            bus.resp_valid = 1'b1;
            bus.resp_fail  = fmask[3'(k)];
            if (fmask[3'(k)]) exp_fail++;
            for (int j = 0; j < 6; j++) exp_res[j] = 16'(5 + 16 * k + 3 * j);
            bus.resp_r0 = exp_res[0];
            bus.resp_r1 = exp_res[1];
            bus.resp_r2 = exp_res[2];
            bus.resp_r3 = exp_res[3];
            bus.resp_r4 = exp_res[4];
            bus.resp_r5 = exp_res[5];
            tick();
        end
        bus.resp_valid = 1'b0;
        bus.resp_fail  = 1'b0;
        lat = 0;
        while (!bus.done && lat < 20) begin
            tick();
            lat++;
        end
        chk("done_pulse", 32'(bus.done), 32'd1);
        chk("fail_count", 32'(bus.fail_count), 32'(exp_fail));
        chk("timeout", 32'(bus.timeout), 32'(n_resp < n_iss));
        chk("res_0", 32'(bus.res_0), 32'(exp_res[0]));
        chk("res_1", 32'(bus.res_1), 32'(exp_res[1]));
        chk("res_2", 32'(bus.res_2), 32'(exp_res[2]));
        chk("res_3", 32'(bus.res_3), 32'(exp_res[3]));
        chk("res_4", 32'(bus.res_4), 32'(exp_res[4]));
        chk("res_5", 32'(bus.res_5), 32'(exp_res[5]));
        tick();
        chk("done_one_cycle", 32'(bus.done), 32'd0);
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("idle_ready", 32'(bus.load_ready), 32'd1);
    endtask

    initial begin
        int n_iss;
        int lat;
        bus.load_valid = 1'b0;
        bus.load_op    = 3'd0;
        bus.load_rs    = 3'd0;
        bus.load_rt    = 3'd0;
        bus.load_rd    = 3'd0;
        bus.load_imm   = 16'd0;
        bus.start      = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_fail  = 1'b0;
        bus.resp_r0 = 16'd0; bus.resp_r1 = 16'd0; bus.resp_r2 = 16'd0;
        bus.resp_r3 = 16'd0; bus.resp_r4 = 16'd0; bus.resp_r5 = 16'd0;
        tick();
        tick();
        chk("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_instr", bus.instr, 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_timeout", 32'(bus.timeout), 32'd0);
        chk("rst_fail", 32'(bus.fail_count), 32'd0);
        chk("rst_res_0", 32'(bus.res_0), 32'd0);
        rst = 1'b0;
        tick();
        chk("empty_ready", 32'(bus.load_ready), 32'd1);

        // Single ADDI, one response
        do_load(3'd6, 3'd0, 3'd0, 3'd0, 16'd5);
        run_prog(1, 8'h00, n_iss, lat);
        chk("addi_count", 32'(n_iss), 32'd1);
        chk("addi_latency", 32'(lat), 32'd0);
        chk("addi_word", log_q[0], 32'h2231_0005);
        chk_empty_start();

        // Responses outside ISSUE/DRAIN are ignored
        bus.resp_valid = 1'b1;
        bus.resp_fail  = 1'b1;
        bus.resp_r0    = 16'hBEEF;
        tick();
        bus.resp_valid = 1'b0;
        bus.resp_fail  = 1'b0;
        tick();
        chk("idle_resp_fail", 32'(bus.fail_count), 32'd0);
        chk("idle_resp_res", 32'(bus.res_0), 32'd5);

        // ADD encoding
        do_load(3'd0, 3'd0, 3'd1, 3'd2, 16'd0);
        run_prog(1, 8'h00, n_iss, lat);
        chk("add_word", log_q[0], 32'h0232_4020);
        chk_empty_start();

        // ILLEGAL then ADDI back-to-back, first response fails
        do_load(3'd7, 3'd1, 3'd2, 3'd3, 16'd0);
        do_load(3'd6, 3'd2, 3'd3, 3'd0, 16'hFFFF);
        run_prog(2, 8'h01, n_iss, lat);
        chk("ill_count", 32'(n_iss), 32'd2);
        chk("ill_word", log_q[0], 32'hFC00_0000);
        chk_empty_start();

        // Nine loads: ninth is dropped; pointers wrap
        for (int k = 0; k < 9; k++) begin
            do_load(3'(k % 8), 3'(k), 3'((k + 3) % 8), 3'((k + 5) % 8), 16'(k * 1111 + 7));
        end
        run_prog(8, 8'hA0, n_iss, lat);
        chk("full_count", 32'(n_iss), 32'd8);
        chk_empty_start();

        // Two issued, one response: drain timeout
        do_load(3'd0, 3'd3, 3'd4, 3'd5, 16'd0);
        do_load(3'd3, 3'd5, 3'd0, 3'd1, 16'd0);
        run_prog(1, 8'h00, n_iss, lat);
        chk("to_count", 32'(n_iss), 32'd2);
        chk("to_latency", 32'(lat), 32'd8);
        tick();
        chk("timeout_held", 32'(bus.timeout), 32'd1);

        // Reset in the middle of a four-instruction run
        do_load(3'd0, 3'd1, 3'd2, 3'd3, 16'd0);
        do_load(3'd1, 3'd2, 3'd3, 3'd4, 16'd0);
        do_load(3'd2, 3'd3, 3'd4, 3'd5, 16'd0);
        do_load(3'd3, 3'd4, 3'd5, 3'd6, 16'd0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        chk("abort_issue_1", 32'(bus.instr_valid), 32'd1);
        tick();
        chk("abort_issue_2", 32'(bus.instr_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_valid", 32'(bus.instr_valid), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_timeout", 32'(bus.timeout), 32'd0);
        q_exp.delete();
        tick();
        rst = 1'b0;
        tick();
        chk_empty_start();

        // Shift encodings after reset
        do_load(3'd4, 3'd0, 3'd3, 3'd4, 16'h0025);
        do_load(3'd5, 3'd2, 3'd5, 3'd1, 16'd31);
        run_prog(2, 8'h02, n_iss, lat);
        chk("shift_count", 32'(n_iss), 32'd2);
        chk("sll_word", log_q[0], 32'h0017_F940);
        chk_empty_start();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
